coffee_order_ctrl: RTL and testbench
====================================

Name: coffee_order_ctrl

Overview:
- Front-end order controller that drives the brewing FSM's start/coffee_sel interface, as the initiator side of that handshake.
- Debounces the three drink buttons (espresso, latte, cappuccino) and a cancel button, and queues orders in a small FIFO.
- Issues one order at a time: a clean start rising edge with coffee_sel held stable.
- Consumes the FSM's state/done outputs to sequence orders and to count drinks served.

Parameters:
DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles before a button level is accepted (20 ms at 50 MHz)
QUEUE_DEPTH, 4, order FIFO entries (power of 2, >=2)
ACK_TIMEOUT, 1_000, cycles allowed for the FSM to leave IDLE after start rises

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
btn_e  in  1  raw espresso button, active-high, asynchronous to clk
btn_l  in  1  raw latte button
btn_c  in  1  raw cappuccino button
btn_cancel  in  1  raw cancel button (flushes queued, not in-flight, orders)
fsm_state  in  3  brewing FSM state (0=IDLE, 6=END)
fsm_done  in  1  brewing FSM done flag
start  out  1  start request to brewing FSM
coffee_sel  out  2  drink code 00=E, 01=L, 10=C; 11 never driven
busy  out  1  high in any issue state other than IDLE
queue_count  out  $clog2(QUEUE_DEPTH)+1  orders waiting
reject  out  1  one-cycle pulse when a request is dropped
fault  out  1  one-cycle pulse on ack timeout
served_count  out  8  completed drinks, wraps 255->0

Behaviour:
- Reset: one clock and one synchronous, active-high reset; all state is cleared on the next clk edge with reset high.
  - Reset values: start=0, coffee_sel=00, busy=0, queue_count=0, reject=0, fault=0, served_count=0.
  - FIFO is emptied, debounce counters cleared, debounced levels=0, issue FSM returns to IDLE.
- Input conditioning: each button goes through a 2-FF synchronizer, then a debounce counter.
  - The debounced level changes only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any bounce restarts the count.
  - A 0->1 transition of a debounced level produces a one-cycle request pulse.
  - Latency from a clean raw edge to the request pulse is DEBOUNCE_CYCLES+3 cycles.
- Simultaneous drink requests in one cycle: priority E > L > C. The highest is pushed; each lower one is dropped and reject pulses once for that cycle.
- Push rules:
  - Push when queue_count < QUEUE_DEPTH, or when a pop happens in the same cycle (count unchanged).
  - Push while full with no pop: order dropped, reject=1 for one cycle.
- Cancel pulse: FIFO cleared (queue_count=0 next cycle).
  - A drink request in the same cycle is also discarded, with no reject.
  - An in-flight order is unaffected.
- Issue FSM:
  - IDLE: if queue_count>0 and fsm_state==0, pop the head, latch it into coffee_sel, go to ISSUE. start is 0.
  - ISSUE: start=1, and an ack timer counts.
    - fsm_state!=0 -> start=0, go to WAIT_DONE.
    - Timer reaches ACK_TIMEOUT -> start=0, fault pulse, order discarded, go to WAIT_IDLE.
  - WAIT_DONE: wait for fsm_done==1. On the first cycle seen, served_count+=1 (mod 256), go to WAIT_IDLE.
  - WAIT_IDLE: wait for fsm_state==0, then go to IDLE.
- Cycle rules:
  - start is low for at least one cycle between orders, so every order presents a fresh rising edge.
  - coffee_sel is held constant from the pop through WAIT_IDLE, because the FSM samples it throughout brewing. It changes only at the next pop.
  - The minimum gap between start rising and the next pop is 3 cycles.
- Unexpected inputs: fsm_done high outside WAIT_DONE is ignored.

Test Plan (DEBOUNCE_CYCLES=4, ACK_TIMEOUT=16, QUEUE_DEPTH=4, FSM model acks 2 cycles after start and is done 20 cycles later):
- Clean btn_l press held 10 cycles -> after 7 cycles one push; start rises with coffee_sel=01; start falls once fsm_state=1; served_count=1 after fsm_done.
- btn_e pulsing 0/1 every 2 cycles for 20 cycles, then held high -> no request during the bounce; exactly one order after the stable window.
- btn_e, btn_l and btn_c debounced in the same cycle -> only E queued; reject pulses once; queue_count=1.
- Five presses while the FSM is busy -> queue_count=4; fifth reject=1; orders issued in FIFO order; served_count=5 total excluding the rejected one.
- FSM model never acks -> start high exactly 16 cycles, fault one-cycle pulse, order discarded, next queued order then issued.
- Cancel with 3 queued plus 1 in flight -> queue_count=0; in-flight completes, served_count+1; reset asserted mid-WAIT_DONE -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/coffee_order_ctrl.sv
// Order front-end for the brewing FSM: debounced buttons feed a small order FIFO,
// and an issue FSM hands orders over one at a time on the start/coffee_sel handshake.
module coffee_order_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned QUEUE_DEPTH     = 4,
    parameter int unsigned ACK_TIMEOUT     = 1_000
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           btn_e,
    input  logic                           btn_l,
    input  logic                           btn_c,
    input  logic                           btn_cancel,
    input  logic [2:0]                     fsm_state,
    input  logic                           fsm_done,
    output logic                           start,
    output logic [1:0]                     coffee_sel,
    output logic                           busy,
    output logic [$clog2(QUEUE_DEPTH):0]   queue_count,
    output logic                           reject,
    output logic                           fault,
    output logic [7:0]                     served_count
);
    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned PW = $clog2(QUEUE_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW-1:0] DEPTH = CW'(QUEUE_DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, WAIT_IDLE} state_t;

    // Bit order everywhere: 0=espresso, 1=latte, 2=cappuccino, 3=cancel.
    logic [3:0]    sync1, sync2, level, level_q, req;
    logic [DW-1:0] db_cnt [4];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1   <= '0;
            sync2   <= '0;
            level   <= '0;
            level_q <= '0;
            req     <= '0;
            for (int unsigned i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            sync1   <= {btn_cancel, btn_c, btn_l, btn_e};
            sync2   <= sync1;
            level_q <= level;
            req     <= level & ~level_q;
            for (int unsigned i = 0; i < 4; i++) begin
                if (sync2[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    level[i]  <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    logic          drink_req, lower_drop, cancel, pop, push, room;
    logic [1:0]    drink_code;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [1:0]    fifo [QUEUE_DEPTH];
    state_t        state;
    logic [TW-1:0] timer;

    always_comb begin
        drink_req  = |req[2:0];
        drink_code = 2'b00;
        lower_drop = 1'b0;
        if (req[0]) begin
            drink_code = 2'b00;
            lower_drop = req[1] | req[2];
        end else if (req[1]) begin
            drink_code = 2'b01;
            lower_drop = req[2];
        end else if (req[2]) begin
            drink_code = 2'b10;
        end
        cancel = req[3];
        pop    = (state == IDLE) && (queue_count != '0) && (fsm_state == 3'd0);
        room   = (queue_count < DEPTH) || pop;
        push   = drink_req && !cancel && room;
    end

    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= drink_code;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            queue_count <= '0;
            reject      <= 1'b0;
        end else begin
            reject <= drink_req && !cancel && (lower_drop || !room);
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            // Cancel empties the queue by snapping the write pointer onto the next read slot.
            if (cancel) begin
                wr_ptr      <= pop ? rd_ptr + 1'b1 : rd_ptr;
                queue_count <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                queue_count <= queue_count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            start        <= 1'b0;
            coffee_sel   <= 2'b00;
            busy         <= 1'b0;
            fault        <= 1'b0;
            served_count <= '0;
            timer        <= '0;
        end else begin
            fault <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        coffee_sel <= fifo[rd_ptr];
                        start      <= 1'b1;
                        busy       <= 1'b1;
                        timer      <= '0;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (fsm_state != 3'd0) begin
                        start <= 1'b0;
                        state <= WAIT_DONE;
                    end else if (timer == TW'(ACK_TIMEOUT - 1)) begin
                        start <= 1'b0;
                        fault <= 1'b1;
                        state <= WAIT_IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (fsm_done) begin
                        served_count <= served_count + 1'b1;
                        state        <= WAIT_IDLE;
                    end
                end
                WAIT_IDLE: begin
                    if (fsm_state == 3'd0) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_coffee_order_ctrl.sv
// Bench for coffee_order_ctrl: button stimulus, a behavioural brewing FSM, an order-level
// reference model feeding a scoreboard, and a monitor that checks each issued order.
`timescale 1ns/1ps
module tb_coffee_order_ctrl;
    localparam int D   = 4;
    localparam int QD  = 4;
    localparam int ACK = 16;

    logic       clk = 1'b0;
    logic       reset, btn_e, btn_l, btn_c, btn_cancel, fsm_done;
    logic [2:0] fsm_state;
    logic       start, busy, reject, fault;
    logic [1:0] coffee_sel;
    logic [2:0] queue_count;
    logic [7:0] served_count;

    always #5 clk = ~clk;

    coffee_order_ctrl #(.DEBOUNCE_CYCLES(D), .QUEUE_DEPTH(QD), .ACK_TIMEOUT(ACK)) dut (
        .clk(clk), .reset(reset), .btn_e(btn_e), .btn_l(btn_l), .btn_c(btn_c),
        .btn_cancel(btn_cancel), .fsm_state(fsm_state), .fsm_done(fsm_done),
        .start(start), .coffee_sel(coffee_sel), .busy(busy), .queue_count(queue_count),
        .reject(reject), .fault(fault), .served_count(served_count)
    );

    int errors = 0;
    int checks = 0;

    // Order-level reference: expected issue order, waiting-order count, and event totals.
    logic [1:0] exp_issue [$];
    int  pending    = 0;
    bit  model_busy = 0;
    int  served_exp = 0;
    int  rej_exp    = 0;
    int  fault_exp  = 0;
    int  rej_seen   = 0;
    int  fault_seen = 0;

    int brew_len = 20;
    int nstart   = 0;
    int skip_at  = -1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic void model_request(input logic [3:0] m);
        int first = -1;
        bit drop = 0;
        if (m[3]) begin
            served_exp -= pending;
            exp_issue.delete();
            pending = 0;
            return;
        end
        for (int i = 0; i < 3; i++) begin
            if (m[i]) begin
                if (first < 0) first = i;
                else drop = 1;
            end
        end
        if (first < 0) return;
        if (!model_busy) begin
            model_busy = 1;
            exp_issue.push_back(2'(first));
            served_exp++;
        end else if (pending < QD) begin
            pending++;
            exp_issue.push_back(2'(first));
            served_exp++;
        end else begin
            drop = 1;
        end
        if (drop) rej_exp++;
    endfunction

    task automatic drive(input logic [3:0] v);
        @(negedge clk);
        btn_e      = v[0];
        btn_l      = v[1];
        btn_c      = v[2];
        btn_cancel = v[3];
    endtask

    task automatic press(input logic [3:0] m, input int hold, input int bounce);
        model_request(m);
        for (int i = 0; i < bounce; i++) drive(((i / 2) % 2 == 0) ? m : 4'b0000);
        for (int i = 0; i < hold; i++) drive(m);
        for (int i = 0; i < 8; i++) drive(4'b0000);
    endtask

    task automatic drain(input string name);
        int n = 0;
        brew_len = 20;
        while ((busy || queue_count != 0 || exp_issue.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drain_in_time"}, int'(n < 3000), 1);
        repeat (3) @(negedge clk);
        model_busy = 0;
        pending    = 0;
        check({name, "_served"}, served_count, served_exp % 256);
        check({name, "_rejects"}, rej_seen, rej_exp);
        check({name, "_faults"}, fault_seen, fault_exp);
        check({name, "_queue_empty"}, queue_count, 0);
    endtask

    task automatic check_reset_values(input string name);
        check({name, "_start"}, start, 0);
        check({name, "_sel"}, coffee_sel, 0);
        check({name, "_busy"}, busy, 0);
        check({name, "_qcount"}, queue_count, 0);
        check({name, "_reject"}, reject, 0);
        check({name, "_fault"}, fault, 0);
        check({name, "_served"}, served_count, 0);
    endtask

    // Brewing FSM stand-in: acks 2 cycles after start, done brew_len cycles later.
    initial begin
        int ph = 0;
        int cnt = 0;
        bit skip = 0;
        fsm_state = 3'd0;
        fsm_done  = 1'b0;
        forever begin
            @(negedge clk);
            fsm_done = 1'b0;
            if (reset) begin
                ph = 0;
                fsm_state = 3'd0;
            end else begin
                case (ph)
                    0: if (start) begin
                        ph = 1;
                        cnt = 0;
                        skip = (nstart == skip_at);
                        nstart++;
                    end
                    1: begin
                        cnt++;
                        if (skip) begin
                            if (!start) ph = 0;
                        end else if (cnt >= 2) begin
                            fsm_state = 3'd1;
                            ph = 2;
                            cnt = 0;
                        end
                    end
                    2: begin
                        cnt++;
                        if (cnt >= brew_len) begin
                            fsm_done = 1'b1;
                            fsm_state = 3'd6;
                            ph = 3;
                        end
                    end
                    default: begin
                        fsm_state = 3'd0;
                        ph = 0;
                    end
                endcase
            end
        end
    end

    // Monitor: pops the scoreboard on every start rising edge.
    initial begin
        logic       prev_start = 1'b0;
        int         hi = 0;
        logic [1:0] cur = 2'b00;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                prev_start = 1'b0;
                hi = 0;
                continue;
            end
            if (reject) rej_seen++;
            if (fault) begin
                fault_seen++;
                check("fault_start_high_cycles", hi, ACK);
            end
            if (start && !prev_start) begin
                hi = 0;
                if (exp_issue.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_issue: coffee_sel=%0d with no order expected", coffee_sel);
                end else begin
                    cur = exp_issue.pop_front();
                    check("issue_order_sel", coffee_sel, cur);
                end
            end
            if (!start && prev_start && !fault) check("start_fall_on_ack", int'(fsm_state != 3'd0), 1);
            if (start) hi++;
            if (busy) check("sel_held_while_busy", coffee_sel, cur);
            prev_start = start;
        end
    end

    initial begin
        int n;
        btn_e = 0; btn_l = 0; btn_c = 0; btn_cancel = 0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Clean latte press
        press(4'b0010, 10, 0);
        drain("latte");

        // Bouncing espresso: nothing may be accepted during the bounce
        model_request(4'b0001);
        for (int i = 0; i < 20; i++) drive(((i / 2) % 2 == 0) ? 4'b0000 : 4'b0001);
        check("bounce_no_order", busy, 0);
        for (int i = 0; i < 8; i++) drive(4'b0001);
        for (int i = 0; i < 8; i++) drive(4'b0000);
        drain("bounce");

        // E, L and C debounced together while an order is in flight
        brew_len = 400;
        press(4'b0100, 6, 0);
        press(4'b0111, 6, 0);
        check("simul_qcount", queue_count, 1);
        drain("simul");

        // Five presses behind an in-flight order: the fifth is dropped
        brew_len = 400;
        press(4'b0001, 6, 0);
        press(4'b0010, 6, 0);
        press(4'b0100, 6, 0);
        press(4'b0001, 6, 0);
        press(4'b0100, 6, 0);
        press(4'b0010, 6, 0);
        check("full_qcount", queue_count, 4);
        drain("full");

        // Ack timeout on the first order; the queued one follows
        skip_at = nstart;
        fault_exp++;
        served_exp--;
        press(4'b0010, 6, 0);
        press(4'b0100, 6, 0);
        drain("timeout");

        // Cancel with three queued and one in flight
        brew_len = 400;
        press(4'b0001, 6, 0);
        press(4'b0010, 6, 0);
        press(4'b0100, 6, 0);
        press(4'b0010, 6, 0);
        check("precancel_qcount", queue_count, 3);
        press(4'b1000, 6, 0);
        check("cancel_qcount", queue_count, 0);
        drain("cancel");

        // Randomized rounds
        for (int r = 0; r < 5; r++) begin
            int cnt_p;
            brew_len = 400;
            cnt_p = $urandom_range(1, 6);
            for (int k = 0; k < cnt_p; k++) begin
                logic [3:0] m;
                m = 4'(1 << $urandom_range(0, 2));
                if ($urandom_range(0, 3) == 0) m = m | 4'(1 << $urandom_range(0, 2));
                press(m, $urandom_range(5, 9), 8 * $urandom_range(0, 1));
            end
            if ($urandom_range(0, 2) == 0) press(4'b1000, 6, 0);
            check("rand_qcount", queue_count, pending);
            drain("rand");
        end

        // Reset while the brew is in progress
        brew_len = 400;
        press(4'b0001, 6, 0);
        n = 0;
        while (fsm_state != 3'd1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("reach_wait_done", int'(n < 200), 1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        exp_issue.delete();
        model_busy = 0;
        pending = 0;
        served_exp = 0;
        @(negedge clk);
        check_reset_values("midreset");
        reset = 1'b0;
        brew_len = 20;
        repeat (2) @(negedge clk);
        press(4'b0100, 6, 0);
        drain("postreset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
